// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration on conflict (default: load/store has priority).
module mem_arbiter #(
  parameter int WORD   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [WORD-1:0]   if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [WORD-1:0]   ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [WORD-1:0]   ls_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD-1:0]   mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [WORD-1:0]   mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD-1:0]   wdata_q, wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [WORD-1:0]   if_rdata_q, if_rdata_d;
  logic [WORD-1:0]   ls_rdata_q, ls_rdata_d;
  logic              pick_ls;
  logic              if_gnt, ls_gnt;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;

  // On conflict the port not granted last time wins.
  assign pick_ls = ls_req_i && (!if_req_i || (last_owner_q == OWN_IF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_IF;
    end else if (if_gnt || ls_gnt) begin
      last_owner_q <= ls_gnt ? OWN_LS : OWN_IF;
    end
  end
`else
  assign pick_ls = ls_req_i;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_ls) begin
          ls_gnt  = 1'b1;
          owner_d = OWN_LS;
          we_d    = ls_we_i;
          addr_d  = ls_addr_i;
          wdata_d = ls_wdata_i;
          state_d = S_WAIT;
        end else if (if_req_i) begin
          if_gnt  = 1'b1;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          wdata_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          state_d = S_IDLE;
          if (owner_q == OWN_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = we_q ? '0 : mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Memory-side outputs are qualified by WAIT so they read 0 while idle.
  assign busy_o      = (state_q == S_WAIT);
  assign mem_req_o   = busy_o;
  assign mem_we_o    = busy_o & we_q;
  assign mem_addr_o  = busy_o ? addr_q  : '0;
  assign mem_wdata_o = busy_o ? wdata_q : '0;

  assign if_gnt_o    = if_gnt;
  assign ls_gnt_o    = ls_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch path and the load/store path of the multicycle core.
- Each requester uses a req/gnt handshake plus a one-cycle rvalid response.
- Only one memory transaction is outstanding at a time.
- Sits between the core sequencer (fetch/LSU request sources) and the memory model; the memory may stall any number of cycles via mem_ready_i.

Parameters:
- WORD, 32, data width in bits
- ADDR_W, 32, address width in bits

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held with if_addr_i stable until granted
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle (combinational)
- if_rvalid_o  out  1  one-cycle pulse, if_rdata_o valid
- if_rdata_o  out  WORD  fetched instruction
- ls_req_i  in  1  load/store request; held with its payload until granted
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  ADDR_W  data address
- ls_wdata_i  in  WORD  store data
- ls_gnt_o  out  1  load/store request accepted this cycle (combinational)
- ls_rvalid_o  out  1  one-cycle pulse: load data valid or store done
- ls_rdata_o  out  WORD  load data; 0 for stores
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  WORD  memory write data
- mem_ready_i  in  1  memory completes the current access this cycle
- mem_rdata_i  in  WORD  read data, valid when mem_ready_i=1
- busy_o  out  1  transaction outstanding (state != IDLE)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; the owner register, captured address/wdata/we and the response data registers are cleared.
- States:
  - IDLE: no transaction outstanding.
  - WAIT: mem_req_o=1, waiting for mem_ready_i.
- IDLE:
  - With any request present, assert exactly one gnt_o combinationally in the same cycle.
  - On that edge, latch owner, addr, we (0 for fetch), wdata (0 for fetch); go to WAIT.
  - No request: stay in IDLE.
- Arbitration (default): fixed priority, load/store wins over fetch when both request.
  - Fetch acts as if_we=0.
  - gnt_o is never asserted in WAIT; if_gnt_o and ls_gnt_o are never both 1.
- WAIT:
  - mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o are driven from the latched registers and are stable for the whole state.
  - On mem_ready_i=1: register mem_rdata_i (or 0 if we) into the owner's rdata register and pulse the owner's rvalid_o on the next cycle; return to IDLE.
- Latency:
  - Grant at cycle N gives mem_req_o=1 from N+1.
  - mem_ready_i at cycle M gives rvalid_o=1 and rdata valid at M+1.
  - Zero-wait memory (ready at N+1) gives rvalid at N+2.
- Back-to-back: the cycle carrying rvalid is IDLE, so a new grant may occur in that same cycle. Peak rate is one access per 2 cycles.
- rdata_o holds its last value until the next response for that port; rvalid_o is low except for the 1-cycle pulse.
- mem_ready_i in IDLE is ignored (no rvalid, no state change).
- A requester dropping req_i before grant causes no transaction.
- Changing req payload while req_i=1 and ungranted is a protocol error; no checking required.
- rst_n asserted in WAIT aborts the access: no rvalid is produced for it, and a later mem_ready_i is ignored as IDLE.
- busy_o = (state == WAIT).

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin on conflict.
  - A 1-bit last_owner register (reset value = fetch) gives the grant to the requester that was not granted last.
  - A single requester is always granted.
  - last_owner updates on every grant.
- Undefined: fixed load/store priority as above; no last_owner register.

Test Plan:
- Fetch only, if_addr=0x100, memory ready on first WAIT cycle with rdata=0x00500093 -> if_gnt at N, mem_req N+1 with addr 0x100 and we=0, if_rvalid at N+2 with if_rdata=0x00500093; busy high exactly 1 cycle.
- Store ls_we=1, addr=0x2000, wdata=0xDEADBEEF, memory stalls 3 cycles -> mem_req/mem_we/addr/wdata stable for 4 cycles, ls_rvalid pulse 1 cycle after ready, ls_rdata=0, if_rvalid stays 0.
- if_req and ls_req (load, addr=0x40) both high in IDLE, fixed priority -> ls_gnt first; if_gnt in the ls_rvalid cycle; two accesses complete in order ls then if; gnt never overlap.
- With MEM_ARB_RR_EN, continuous requests from both for 4 accesses -> grant order ls, if, ls, if starting from reset (last_owner=fetch).
- rst_n pulsed low for 1 cycle during WAIT, then mem_ready_i=1 -> no rvalid on either port, all outputs 0, state IDLE, next fetch handled normally.
- mem_ready_i=1 while IDLE with no requests -> no rvalid, busy_o stays 0, rdata outputs unchanged.
